result_merge_unit: RTL

- Sits between execute_stage / pipelined_multiplier and memory_stage.
- Collects completed results from both units and forwards them to the memory stage strictly in program order, using a per-instruction sequence tag issued at decode.
- Absorbs the latency mismatch between the single-cycle ALU and the multi-cycle multiplier.
- Produces the backpressure that stalls execute and freezes the multiplier.

---
 rtl/result_merge_unit_pkg.sv | 22 ++
 rtl/result_merge_unit_sync_fifo.sv | 58 +++++
 rtl/result_merge_unit.sv | 115 +++++++++++
 3 files changed

// File: rtl/result_merge_unit_pkg.sv
// Shared configuration defaults and entry types for the result merge unit.
// Results from execute and the multiplier are tagged and reordered by sequence tag.
package result_merge_unit_pkg;

    localparam int CFG_DATA_W    = 128;
    localparam int CFG_TAG_W     = 4;
    localparam int CFG_EXE_DEPTH = 2;
    localparam int CFG_MUL_DEPTH = 4;

    typedef logic [CFG_TAG_W-1:0] tag_t;

    typedef struct packed {
        tag_t                  tag;
        logic [CFG_DATA_W-1:0] data;
    } merge_entry_t;

    typedef enum logic {
        SRC_EXE = 1'b0,
        SRC_MUL = 1'b1
    } src_t;

endpackage

// File: rtl/result_merge_unit_sync_fifo.sv
// Single-clock FIFO with occupancy count and synchronous clear.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module result_merge_unit_sync_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/result_merge_unit.sv
// Merges execute and multiplier results back into program order by sequence tag
// and presents them to the memory stage through a single output register.
module result_merge_unit
    import result_merge_unit_pkg::*;
#(
    parameter int DATA_W    = CFG_DATA_W,
    parameter int TAG_W     = CFG_TAG_W,
    parameter int EXE_DEPTH = CFG_EXE_DEPTH,
    parameter int MUL_DEPTH = CFG_MUL_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exe_valid_i,
    input  logic [TAG_W-1:0]  exe_tag_i,
    input  logic [DATA_W-1:0] exe_data_i,
    output logic              exe_ready_o,
    input  logic              mul_valid_i,
    input  logic [TAG_W-1:0]  mul_tag_i,
    input  logic [DATA_W-1:0] mul_data_i,
    output logic              mul_stall_o,
    input  logic              flush_i,
    input  logic [TAG_W-1:0]  flush_tag_i,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic [TAG_W-1:0]  mem_tag_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_src_o,
    output logic              err_o
);

    localparam int ENT_W   = TAG_W + DATA_W;
    localparam int EXE_CW  = $clog2(EXE_DEPTH + 1);
    localparam int MUL_CW  = $clog2(MUL_DEPTH + 1);

    logic [ENT_W-1:0]  exe_head;
    logic [ENT_W-1:0]  mul_head;
    logic [EXE_CW-1:0] exe_count;
    logic [MUL_CW-1:0] mul_count;
    logic              exe_empty;
    logic              mul_empty;
    logic              mul_full;
    logic              exe_full_unused;
    logic [TAG_W-1:0]  next_tag;
    logic              loadable;
    logic              exe_match;
    logic              mul_match;
    logic              take_exe;
    logic              take_mul;
    logic              mul_drop;
    logic              dual_match;

    result_merge_unit_sync_fifo #(.DEPTH(EXE_DEPTH), .WIDTH(ENT_W)) u_exe_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush_i),
        .push  (exe_valid_i && exe_ready_o && !flush_i),
        .pop   (take_exe),
        .wdata ({exe_tag_i, exe_data_i}),
        .rdata (exe_head),
        .count (exe_count),
        .full  (exe_full_unused),
        .empty (exe_empty)
    );

    result_merge_unit_sync_fifo #(.DEPTH(MUL_DEPTH), .WIDTH(ENT_W)) u_mul_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush_i),
        .push  (mul_valid_i && !flush_i),
        .pop   (take_mul),
        .wdata ({mul_tag_i, mul_data_i}),
        .rdata (mul_head),
        .count (mul_count),
        .full  (mul_full),
        .empty (mul_empty)
    );

    // Multiplier stalls one entry early because its last stage is already committed.
    assign exe_ready_o = (exe_count < EXE_CW'(EXE_DEPTH));
    assign mul_stall_o = (mul_count >= MUL_CW'(MUL_DEPTH - 1));

    assign loadable   = !mem_valid_o || mem_ready_i;
    assign exe_match  = !exe_empty && (exe_head[ENT_W-1 -: TAG_W] == next_tag);
    assign mul_match  = !mul_empty && (mul_head[ENT_W-1 -: TAG_W] == next_tag);
    assign take_exe   = loadable && exe_match && !flush_i;
    assign take_mul   = loadable && mul_match && !exe_match && !flush_i;
    assign dual_match = loadable && exe_match && mul_match && !flush_i;
    assign mul_drop   = mul_valid_i && !flush_i && mul_full && !take_mul;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_valid_o <= 1'b0;
            mem_tag_o   <= '0;
            mem_data_o  <= '0;
            mem_src_o   <= SRC_EXE;
            next_tag    <= '0;
            err_o       <= 1'b0;
        end else begin
            if (mul_drop || dual_match) err_o <= 1'b1;
            if (flush_i) begin
                mem_valid_o <= 1'b0;
                next_tag    <= flush_tag_i;
            end else if (take_exe || take_mul) begin
                mem_valid_o <= 1'b1;
                mem_tag_o   <= take_exe ? exe_head[ENT_W-1 -: TAG_W] : mul_head[ENT_W-1 -: TAG_W];
                mem_data_o  <= take_exe ? exe_head[DATA_W-1:0] : mul_head[DATA_W-1:0];
                mem_src_o   <= take_exe ? SRC_EXE : SRC_MUL;
                next_tag    <= next_tag + TAG_W'(1);
            end else if (loadable) begin
                mem_valid_o <= 1'b0;
            end
        end
    end

endmodule
